input_conditioner: RTL
======================

// Module: input_conditioner
// PURPOSE
//  Front end for the traffic-light board inputs. It synchronises and debounces the raw push-buttons and slide switches.
//  Buttons produce one-cycle press pulses, with optional auto-repeat while held. Switches produce stable levels plus a change pulse.
//  Outputs feed the controller's btn_i/sw_i directly, so the controller needs no internal debounce counter.
// PARAMETERS
//  N_BTN        3           number of button channels (bit0 = reset-to-default, bit1 = +1 s, bit2 = -1 s)
//  N_SW         2           number of switch channels (mode select)
//  DB_CYCLES    1_000_000   consecutive mismatching clk cycles before a stable level flips (10 ms @ 100 MHz); >= 1
//  RPT_DELAY    50_000_000  clk cycles from press pulse to first repeat pulse; >= 1
//  RPT_RATE     20_000_000  clk cycles between subsequent repeat pulses; >= 1
//  RPT_MASK     3'b110      per-button auto-repeat enable (bit i for btn i); width N_BTN
// PORTS
//  clk_i        in   1      system clock
//  rst_i        in   1      asynchronous, active-high reset
//  btn_raw_i    in   N_BTN  raw button pins, asynchronous to clk_i
//  sw_raw_i     in   N_SW   raw switch pins, asynchronous to clk_i
//  btn_level_o  out  N_BTN  debounced button level
//  btn_pulse_o  out  N_BTN  one-cycle press/repeat pulse, at most one bit set (one-hot or zero)
//  sw_o         out  N_SW   debounced switch level
//  sw_chg_o     out  1      one-cycle pulse when any bit of sw_o changes
// BEHAVIOUR
//  - Reset (async assert, sync-safe release):
//    - All sync flops, stable levels, counters and outputs go to 0.
//  - Synchroniser: 2 flops per channel. Downstream logic uses only the 2nd-stage value s.
//  - Debounce (every channel, independent):
//    - Counter cnt[c] increments while s != stable[c] and clears whenever s == stable[c].
//    - When cnt reaches DB_CYCLES-1 with s still != stable: stable <= s and cnt <= 0.
//    - Any glitch shorter than DB_CYCLES cycles leaves stable untouched.
//    - Latency: raw change sampled at edge 0 -> stable/level output changes at edge 2+DB_CYCLES.
//  - Press pulse: btn_pulse_o[i] is registered and high in the same cycle btn_level_o[i] first reads 1. Release produces no pulse.
//  - Auto-repeat (only when RPT_MASK[i]=1, while btn_level_o[i]=1):
//    - rpt_cnt[i] clears on the press pulse.
//    - A repeat pulse fires RPT_DELAY cycles after the press pulse, then every RPT_RATE cycles.
//    - Release clears rpt_cnt[i] and stops repeats immediately; a pending repeat is never emitted after release.
//  - Arbitration: candidate pulses from several buttons in the same cycle -> lowest index wins.
//    - Losers are dropped, not deferred. Their repeat timers continue unaffected.
//  - sw_chg_o: high for one cycle, the cycle after which sw_o differs from its previous value.
//    - Coincident bit changes give a single pulse.
//  - Button held across reset release: seen as a new press, pulse after 2+DB_CYCLES.
//    - Likewise a nonzero switch after reset gives a sw_chg_o pulse.
//  - Counter widths are $clog2(max+1). No counter wraps; each saturates or clears as stated.
//  - Reset mid-debounce or mid-repeat: everything returns to the reset state, no partial pulse.
// TESTING (bench params: DB_CYCLES=4, RPT_DELAY=10, RPT_RATE=3)
//  1. Raw btn1 0->1 clean at edge 0, held 8 cycles
//     -> btn_level_o[1]=1 from edge 6; btn_pulse_o=3'b010 exactly at edge 6 only.
//  2. btn2 bouncing 1,0,1,0,1 (1-cycle each), then steady 1
//     -> a single pulse, 2+4 edges after the last bounce; no earlier pulse.
//  3. btn1 held 30 cycles after level rise at edge 6
//     -> pulses at edges 6, 16, 19, 22, 25, 28, 31, 34; none after release debounces.
//  4. btn0 and btn1 rise on the same edge; btn0 held 30 cycles (RPT_MASK bit0=0)
//     -> one pulse 3'b001 only; btn1's first pulse dropped; btn1 repeats appear at +10, +13, ...
//  5. sw_raw_i 2'b00 -> 2'b11 at edge 0 -> sw_o=2'b11 at edge 6; sw_chg_o single pulse.
//     Also a 3-cycle glitch to 2'b01 -> sw_o and sw_chg_o unchanged.
//  6. rst_i pulsed while btn1 held mid-repeat -> all outputs 0 asynchronously.
//     After release: new press pulse at 2+4 cycles, then repeat at +10.

Source files
------------

// File: rtl/input_conditioner_if.sv
// Board-input bundle between the raw pin side (master) and the conditioner (slave).
// The conditioner samples the raw pins and returns debounced levels and pulses.
interface input_conditioner_if #(
    parameter int N_BTN = 3,
    parameter int N_SW  = 2
);
    logic [N_BTN-1:0] btn_raw_i;
    logic [N_SW-1:0]  sw_raw_i;
    logic [N_BTN-1:0] btn_level_o;
    logic [N_BTN-1:0] btn_pulse_o;
    logic [N_SW-1:0]  sw_o;
    logic             sw_chg_o;

    modport master (
        output btn_raw_i, sw_raw_i,
        input  btn_level_o, btn_pulse_o, sw_o, sw_chg_o
    );

    modport slave (
        input  btn_raw_i, sw_raw_i,
        output btn_level_o, btn_pulse_o, sw_o, sw_chg_o
    );
endinterface

// File: rtl/input_conditioner.sv
// Synchronises and debounces the board buttons and switches; emits arbitrated press/repeat
// pulses for the buttons and a change pulse for the switches.
module input_conditioner #(
    parameter int               N_BTN     = 3,
    parameter int               N_SW      = 2,
    parameter int               DB_CYCLES = 1_000_000,
    parameter int               RPT_DELAY = 50_000_000,
    parameter int               RPT_RATE  = 20_000_000,
    parameter logic [N_BTN-1:0] RPT_MASK  = N_BTN'(3'b110)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input_conditioner_if.slave  io
);
    localparam int NCH     = N_BTN + N_SW;
    localparam int DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int RPT_MAX = ((RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE) - 1;
    localparam int RPT_W   = (RPT_MAX > 0) ? $clog2(RPT_MAX + 1) : 1;

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(RPT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(RPT_RATE - 1);

    logic [NCH-1:0]   sync1_reg;
    logic [NCH-1:0]   sync2_reg;
    logic [NCH-1:0]   stable;
    logic [N_BTN-1:0] level_reg;
    logic [N_BTN-1:0] pulse_reg;
    logic [N_SW-1:0]  sw_reg;
    logic             sw_chg_reg;

    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] cand;
    logic [N_BTN-1:0] pulse_next;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= {io.sw_raw_i, io.btn_raw_i};
            sync2_reg <= sync1_reg;
        end
    end

    // Each channel flips its stable level only after DB_CYCLES consecutive mismatching samples.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_db
            logic [DB_W-1:0] cnt_reg;
            logic            stable_reg;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt_reg    <= '0;
                    stable_reg <= 1'b0;
                end else if (sync2_reg[gi] == stable_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == DB_LAST) begin
                    stable_reg <= sync2_reg[gi];
                    cnt_reg    <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign stable[gi] = stable_reg;
        end
    endgenerate

    // A press is the cycle where the debounced level is up but the registered level is not yet.
    assign press = stable[N_BTN-1:0] & ~level_reg;

    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_btn
            if (RPT_MASK[gi]) begin : g_rpt
                logic [RPT_W-1:0] rpt_cnt_reg;
                logic             rpt_phase_reg;
                logic [RPT_W-1:0] rpt_target;
                logic             held;
                logic             rpt_hit;

                // Gate on stable as well so a repeat never lands on the cycle the level drops.
                assign held       = stable[gi] & level_reg[gi];
                assign rpt_target = rpt_phase_reg ? RATE_LAST : DELAY_LAST;
                assign rpt_hit    = held & (rpt_cnt_reg == rpt_target);

                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) begin
                        rpt_cnt_reg   <= '0;
                        rpt_phase_reg <= 1'b0;
                    end else if (!held) begin
                        rpt_cnt_reg   <= '0;
                        rpt_phase_reg <= 1'b0;
                    end else if (rpt_hit) begin
                        rpt_cnt_reg   <= '0;
                        rpt_phase_reg <= 1'b1;
                    end else begin
                        rpt_cnt_reg <= rpt_cnt_reg + 1'b1;
                    end
                end

                assign cand[gi] = press[gi] | rpt_hit;
            end else begin : g_norpt
                assign cand[gi] = press[gi];
            end
        end
    endgenerate

    // Lowest-index candidate wins; the others are simply dropped this cycle.
    assign pulse_next = cand & (~cand + 1'b1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_reg  <= '0;
            pulse_reg  <= '0;
            sw_reg     <= '0;
            sw_chg_reg <= 1'b0;
        end else begin
            level_reg  <= stable[N_BTN-1:0];
            pulse_reg  <= pulse_next;
            sw_reg     <= stable[NCH-1:N_BTN];
            sw_chg_reg <= (stable[NCH-1:N_BTN] != sw_reg);
        end
    end

    assign io.btn_level_o = level_reg;
    assign io.btn_pulse_o = pulse_reg;
    assign io.sw_o        = sw_reg;
    assign io.sw_chg_o    = sw_chg_reg;
endmodule
